// File: rtl/serial_work_receiver.sv
// 8N1 UART receiver assembling a 64-byte work unit into midstate/data2, with atomic update and a rx_done pulse.
// Latency: update one cycle after the 64th stop-bit sample (+2 cycles RxD sync); never backpressures the line.
module serial_work_receiver #(
  parameter int comm_clk_frequency = 50_000_000,
  parameter int baud_rate          = 115_200,
  parameter int timeout_cycles     = comm_clk_frequency / 100
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         RxD,
  output logic [255:0] midstate,
  output logic [255:0] data2,
  output logic         rx_done
);

  localparam int BIT  = (comm_clk_frequency + baud_rate / 2) / baud_rate;
  localparam int HALF = BIT / 2;
  localparam int BW   = $clog2(BIT);
  localparam int TW   = $clog2(timeout_cycles + 1);

  localparam logic [BW-1:0] BIT_M1  = BW'(BIT - 1);
  localparam logic [BW-1:0] HALF_M1 = BW'(HALF - 1);
  localparam logic [TW-1:0] TO_LAST = TW'(timeout_cycles - 1);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_START = 3'd1;
  localparam logic [2:0] S_DATA  = 3'd2;
  localparam logic [2:0] S_STOP  = 3'd3;
  localparam logic [2:0] S_BREAK = 3'd4;

  logic           r_rxd_meta;
  logic           r_rxd_sync;
  logic [2:0]     r_state;
  logic [BW-1:0]  r_baud_cnt;
  logic [2:0]     r_bit_idx;
  logic [7:0]     r_shift;
  logic [511:0]   r_buf;
  logic [5:0]     r_byte_cnt;
  logic [TW-1:0]  r_to_cnt;
  logic [511:0]   w_next_buf;

  assign w_next_buf = {r_buf[503:0], r_shift};

  always_ff @(posedge clk) begin
    if (reset) begin
      r_rxd_meta <= 1'b1;
      r_rxd_sync <= 1'b1;
      r_state    <= S_IDLE;
      r_baud_cnt <= '0;
      r_bit_idx  <= '0;
      r_shift    <= '0;
      r_buf      <= '0;
      r_byte_cnt <= '0;
      r_to_cnt   <= '0;
      midstate   <= '0;
      data2      <= '0;
      rx_done    <= 1'b0;
    end else begin
      r_rxd_meta <= RxD;
      r_rxd_sync <= r_rxd_meta;
      rx_done    <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Idle time only counts against a partially received unit.
          if (!r_rxd_sync) begin
            r_state    <= S_START;
            r_baud_cnt <= HALF_M1;
            r_to_cnt   <= '0;
          end else if (r_byte_cnt == 6'd0) begin
            r_to_cnt <= '0;
          end else if (r_to_cnt == TO_LAST) begin
            r_to_cnt   <= '0;
            r_byte_cnt <= '0;
          end else begin
            r_to_cnt <= r_to_cnt + 1'b1;
          end
        end
        S_START: begin
          if (r_baud_cnt != '0) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else if (!r_rxd_sync) begin
            r_state    <= S_DATA;
            r_baud_cnt <= BIT_M1;
            r_bit_idx  <= '0;
          end else begin
            r_state <= S_IDLE;
          end
        end
        S_DATA: begin
          if (r_baud_cnt != '0) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else begin
            r_shift[r_bit_idx] <= r_rxd_sync;
            r_baud_cnt         <= BIT_M1;
            r_bit_idx          <= r_bit_idx + 1'b1;
            if (r_bit_idx == 3'd7) r_state <= S_STOP;
          end
        end
        S_STOP: begin
          if (r_baud_cnt != '0) begin
            r_baud_cnt <= r_baud_cnt - 1'b1;
          end else if (r_rxd_sync) begin
            r_buf      <= w_next_buf;
            r_byte_cnt <= r_byte_cnt + 1'b1;
            r_state    <= S_IDLE;
            if (r_byte_cnt == 6'd63) begin
              midstate <= w_next_buf[511:256];
              data2    <= w_next_buf[255:0];
              rx_done  <= 1'b1;
            end
          end else begin
            // Framing error: drop the unit and hold off until the line returns high.
            r_byte_cnt <= '0;
            r_state    <= S_BREAK;
          end
        end
        S_BREAK: begin
          if (r_rxd_sync) r_state <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_serial_work_receiver.sv
// Directed bench for serial_work_receiver: table of 64-byte units plus hand-written corner sequences.
module tb_serial_work_receiver;
  localparam int CLK_F = 921_600;
  localparam int BAUD  = 115_200;
  localparam int TO    = 400;
  localparam int BIT   = 8;

  logic         clk = 1'b0;
  logic         reset = 1'b1;
  logic         RxD = 1'b1;
  logic [255:0] midstate;
  logic [255:0] data2;
  logic         rx_done;

  always #5 clk = ~clk;

  serial_work_receiver #(
    .comm_clk_frequency(CLK_F),
    .baud_rate(BAUD),
    .timeout_cycles(TO)
  ) dut (
    .clk(clk),
    .reset(reset),
    .RxD(RxD),
    .midstate(midstate),
    .data2(data2),
    .rx_done(rx_done)
  );

  typedef struct {
    logic [7:0]   first;
    logic [7:0]   step;
    logic [255:0] exp_mid;
    logic [255:0] exp_d2;
  } unit_t;

  unit_t vec[5];
  int checks = 0;
  int errors = 0;
  int pulses = 0;

  always @(negedge clk) if (rx_done) pulses++;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop);
    RxD = 1'b0;
    wait_cyc(BIT);
    for (int i = 0; i < 8; i++) begin
      RxD = b[i];
      wait_cyc(BIT);
    end
    RxD = stop;
    wait_cyc(BIT);
  endtask

  task automatic run_unit(input int v, input string name);
    int p0;
    logic [7:0] b;
    p0 = pulses;
    for (int i = 0; i < 64; i++) begin
      b = vec[v].first + vec[v].step * 8'(i);
      send_byte(b, 1'b1);
    end
    wait_cyc(4 * BIT);
    check({name, "_pulses"}, 256'(pulses - p0), 256'd1);
    check({name, "_midstate"}, midstate, vec[v].exp_mid);
    check({name, "_data2"}, data2, vec[v].exp_d2);
  endtask

  initial begin
    int p0;
    vec[0] = '{8'h00, 8'h01,
      256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f,
      256'h202122232425262728292a2b2c2d2e2f303132333435363738393a3b3c3d3e3f};
    vec[1] = '{8'hFF, 8'hFF,
      256'hfffefdfcfbfaf9f8f7f6f5f4f3f2f1f0efeeedecebeae9e8e7e6e5e4e3e2e1e0,
      256'hdfdedddcdbdad9d8d7d6d5d4d3d2d1d0cfcecdcccbcac9c8c7c6c5c4c3c2c1c0};
    vec[2] = '{8'hA5, 8'h00, {32{8'hA5}}, {32{8'hA5}}};
    vec[3] = '{8'h5A, 8'h00, {32{8'h5A}}, {32{8'h5A}}};
    vec[4] = '{8'h11, 8'h01,
      256'h1112131415161718191a1b1c1d1e1f202122232425262728292a2b2c2d2e2f30,
      256'h3132333435363738393a3b3c3d3e3f404142434445464748494a4b4c4d4e4f50};

    wait_cyc(5);
    reset = 1'b0;
    wait_cyc(1);
    check("reset_midstate", midstate, 256'd0);
    check("reset_data2", data2, 256'd0);
    check("reset_rx_done", 256'(rx_done), 256'd0);
    wait_cyc(2000);
    check("idle_no_pulse", 256'(pulses), 256'd0);

    for (int v = 0; v < 2; v++) run_unit(v, $sformatf("unit%0d", v));

    // Partial unit then idle past the timeout: it must be discarded.
    p0 = pulses;
    for (int i = 0; i < 30; i++) send_byte(8'h77, 1'b1);
    wait_cyc(2 * TO + 100);
    check("partial_no_pulse", 256'(pulses - p0), 256'd0);
    check("partial_hold_mid", midstate, vec[1].exp_mid);
    run_unit(2, "after_timeout");

    // Short low glitch shorter than half a bit.
    RxD = 1'b0;
    wait_cyc(2);
    RxD = 1'b1;
    wait_cyc(50);
    run_unit(3, "after_glitch");

    // Framing error on byte 10.
    p0 = pulses;
    for (int i = 0; i < 9; i++) send_byte(8'h22, 1'b1);
    send_byte(8'h00, 1'b0);
    RxD = 1'b1;
    wait_cyc(3 * BIT);
    check("framing_no_pulse", 256'(pulses - p0), 256'd0);
    run_unit(4, "after_framing");

    // Reset pulse in the middle of byte 40.
    for (int i = 0; i < 39; i++) send_byte(8'hFF, 1'b1);
    fork
      send_byte(8'hFF, 1'b1);
      begin
        wait_cyc(30);
        reset = 1'b1;
        wait_cyc(1);
        reset = 1'b0;
      end
    join
    wait_cyc(100);
    check("midreset_midstate", midstate, 256'd0);
    check("midreset_data2", data2, 256'd0);
    run_unit(0, "after_reset");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
